// File: rtl/adxl362_pkg.sv
// Shared constants, reset-value table and FSM state type for the ADXL362 SPI register responder.
package adxl362_pkg;

    localparam logic [7:0] CMD_WRITE      = 8'h0A;
    localparam logic [7:0] CMD_READ       = 8'h0B;

    localparam logic [7:0] REG_DEVICEID   = 8'h00;
    localparam logic [7:0] REG_DEVID_MST  = 8'h01;
    localparam logic [7:0] REG_PARTID     = 8'h02;
    localparam logic [7:0] REG_REVID      = 8'h03;
    localparam logic [7:0] REG_STATUS     = 8'h0B;
    localparam logic [7:0] REG_RO_LAST    = 8'h0E;
    localparam logic [7:0] REG_SOFT_RESET = 8'h1F;

    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

    // IDLE wait CS fall | CMD command byte | ADDR address byte | WDATA write | RDATA read | IGNORE until CS high
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    function automatic logic [7:0] reg_reset_val(input logic [7:0] addr);
        logic [7:0] val;
        case (addr)
            REG_DEVICEID:  val = 8'hAD;
            REG_DEVID_MST: val = 8'h1D;
            REG_PARTID:    val = 8'hF2;
            REG_REVID:     val = 8'h01;
            REG_STATUS:    val = 8'h41;
            default:       val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/adxl362_responder_if.sv
// SPI bus between an initiator (master) and the ADXL362 responder (slave).
interface adxl362_responder_if;
    logic SPI_SCLK;
    logic SPI_MOSI;
    logic SPI_CS;
    logic SPI_MISO;

    modport master (output SPI_SCLK, output SPI_MOSI, output SPI_CS, input SPI_MISO);
    modport slave  (input SPI_SCLK, input SPI_MOSI, input SPI_CS, output SPI_MISO);
endinterface

// File: rtl/adxl362_responder_spi_sync_edge.sv
// Two-flop synchronizer with rise/fall pulses; edges stay masked until the pipeline holds only sampled data.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);
    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [2:0] vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
            vld_q  <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            vld_q  <= {vld_q[1:0], 1'b1};
        end
    end

    // Without the mask, a line held low through reset would look like a fresh falling edge.
    assign sync_o = sync_q;
    assign rise_o = vld_q[2] & sync_q & ~prev_q;
    assign fall_o = vld_q[2] & ~sync_q & prev_q;
endmodule

// File: rtl/adxl362_responder.sv
// SPI mode-0 register-file responder emulating the ADXL362 command set.
// Define ADXL362_AUTOINC_EN to enable burst access with address auto-increment.
module adxl362_responder
    import adxl362_pkg::*;
#(
    parameter int CLK_FREQUENCY  = 100_000_000,
    parameter int SCLK_FREQUENCY = 500_000,
    parameter int NUM_REGS       = 64
) (
    input  logic                clk,
    input  logic                rst,
    adxl362_responder_if.slave  spi,
    output logic                busy,
    output logic                wr_strobe,
    output logic [7:0]          wr_addr,
    output logic [7:0]          wr_data,
    output logic                soft_rst,
    output logic                cmd_err
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    if (CLK_FREQUENCY < 8 * SCLK_FREQUENCY) begin : g_chk_clk
        $error("adxl362_responder: CLK_FREQUENCY must be at least 8x SCLK_FREQUENCY");
    end
    if (NUM_REGS < 2 || NUM_REGS > 256 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_chk_regs
        $error("adxl362_responder: NUM_REGS must be a power of two between 2 and 256");
    end

    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic cs_s, cs_rise, cs_fall;
    logic unused_sync;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .async_i(spi.SPI_SCLK),
        .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .async_i(spi.SPI_MOSI),
        .sync_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .async_i(spi.SPI_CS),
        .sync_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    assign unused_sync = ^{sclk_s, mosi_rise, mosi_fall};

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [7:0] addr_q;
    logic       is_rd_q;
    logic [7:0] miso_sr_q;
    logic       miso_q;
    logic       wr_strobe_q;
    logic [7:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic       soft_pend_q;
    logic       soft_rst_q;
    logic       cmd_err_q;
    logic [7:0] regs_q [NUM_REGS];

    logic [7:0] byte_in;
    logic       byte_done;

    assign byte_in   = {shift_q[6:0], mosi_s};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

    function automatic logic [7:0] reg_read(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h00;
        if (int'(a) < NUM_REGS) v = regs_q[a[AW-1:0]];
        return v;
    endfunction

    function automatic logic writable(input logic [7:0] a);
        return (a > REG_RO_LAST) && (int'(a) < NUM_REGS);
    endfunction

    always_ff @(posedge clk) begin
        wr_strobe_q <= 1'b0;
        soft_rst_q  <= 1'b0;
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            is_rd_q     <= 1'b0;
            miso_sr_q   <= '0;
            miso_q      <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            soft_pend_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reg_reset_val(8'(i));
        end else if (cs_rise) begin
            // Any partial byte in shift_q is simply abandoned here.
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            miso_q      <= 1'b0;
            soft_pend_q <= 1'b0;
            if (soft_pend_q) begin
                soft_rst_q <= 1'b1;
                for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reg_reset_val(8'(i));
            end
        end else begin
            if (sclk_rise && state_q != ST_IDLE && state_q != ST_IGNORE) begin
                shift_q   <= byte_in;
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_q   <= ST_CMD;
                        bit_cnt_q <= '0;
                        cmd_err_q <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (byte_done) begin
                        if (byte_in == CMD_WRITE || byte_in == CMD_READ) begin
                            state_q <= ST_ADDR;
                            is_rd_q <= (byte_in == CMD_READ);
                        end else begin
                            state_q   <= ST_IGNORE;
                            cmd_err_q <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (byte_done) begin
                        addr_q <= byte_in;
                        if (is_rd_q) begin
                            state_q   <= ST_RDATA;
                            miso_sr_q <= reg_read(byte_in);
                        end else begin
                            state_q <= ST_WDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    if (byte_done) begin
                        if (writable(addr_q)) begin
                            regs_q[addr_q[AW-1:0]] <= byte_in;
                            wr_strobe_q <= 1'b1;
                            wr_addr_q   <= addr_q;
                            wr_data_q   <= byte_in;
                            if (addr_q == REG_SOFT_RESET && byte_in == SOFT_RESET_KEY) soft_pend_q <= 1'b1;
                        end
`ifdef ADXL362_AUTOINC_EN
                        addr_q <= addr_q + 8'd1;
`else
                        state_q <= ST_IGNORE;
`endif
                    end
                end
                ST_RDATA: begin
                    if (sclk_fall) begin
                        miso_q    <= miso_sr_q[7];
                        miso_sr_q <= {miso_sr_q[6:0], 1'b0};
                    end
                    if (byte_done) begin
`ifdef ADXL362_AUTOINC_EN
                        addr_q    <= addr_q + 8'd1;
                        miso_sr_q <= reg_read(addr_q + 8'd1);
`else
                        state_q <= ST_IGNORE;
                        miso_q  <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign spi.SPI_MISO = miso_q;
    assign busy         = ~cs_s;
    assign wr_strobe    = wr_strobe_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign soft_rst     = soft_rst_q;
    assign cmd_err      = cmd_err_q;
endmodule

// File: tb/tb_adxl362_responder.sv
// Directed bench for adxl362_responder: SPI initiator tasks plus hand-computed expectations.
module tb_adxl362_responder;
    localparam int HALF = 80;

`ifdef ADXL362_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       busy, wr_strobe, soft_rst, cmd_err;
    logic [7:0] wr_addr, wr_data;

    adxl362_responder_if spi_bus();

    adxl362_responder dut (
        .clk(clk), .rst(rst), .spi(spi_bus.slave),
        .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .soft_rst(soft_rst), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         strobe_cnt = 0;
    int         soft_cnt = 0;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] last_data = 8'h00;
    logic       busy_mid, busy_end;
    logic [7:0] tx_buf [4];
    logic [7:0] rx_buf [4];
    logic [7:0] r;

    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt++;
            last_addr = wr_addr;
            last_data = wr_data;
        end
        if (soft_rst) soft_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cs_low();
        spi_bus.SPI_CS = 1'b0;
        #(2*HALF);
        busy_mid = busy;
    endtask

    task automatic cs_high();
        #HALF;
        busy_end = busy;
        spi_bus.SPI_CS   = 1'b1;
        spi_bus.SPI_MOSI = 1'b0;
        #(3*HALF);
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_bus.SPI_MOSI = tx[i];
            #HALF;
            rx = {rx[6:0], spi_bus.SPI_MISO};
            spi_bus.SPI_SCLK = 1'b1;
            #HALF;
            spi_bus.SPI_SCLK = 1'b0;
        end
    endtask

    task automatic spi_txn(input int nbytes, input int last_bits);
        int nb;
        cs_low();
        for (int b = 0; b < nbytes; b++) begin
            nb = (b == nbytes - 1) ? last_bits : 8;
            spi_byte(tx_buf[b], nb, rx_buf[b]);
        end
        cs_high();
    endtask

    task automatic do_read(input logic [7:0] a, output logic [7:0] d);
        tx_buf[0] = 8'h0B; tx_buf[1] = a; tx_buf[2] = 8'h00;
        spi_txn(3, 8);
        d = rx_buf[2];
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        tx_buf[0] = 8'h0A; tx_buf[1] = a; tx_buf[2] = d;
        spi_txn(3, 8);
    endtask

    initial begin
        rst = 1'b1;
        spi_bus.SPI_CS   = 1'b1;
        spi_bus.SPI_SCLK = 1'b0;
        spi_bus.SPI_MOSI = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        check("rst_busy",      busy,             0);
        check("rst_miso",      spi_bus.SPI_MISO, 0);
        check("rst_wr_strobe", wr_strobe,        0);
        check("rst_wr_addr",   wr_addr,          0);
        check("rst_wr_data",   wr_data,          0);
        check("rst_soft_rst",  soft_rst,         0);
        check("rst_cmd_err",   cmd_err,          0);

        do_read(8'h00, r);
        check("read_devid",   r,        8'hAD);
        check("busy_mid",     busy_mid, 1);
        check("busy_end",     busy_end, 1);
        check("busy_idle",    busy,     0);

        do_write(8'h20, 8'h5A);
        check("wr20_count", strobe_cnt, 1);
        check("wr20_addr",  last_addr,  8'h20);
        check("wr20_data",  last_data,  8'h5A);
        do_read(8'h20, r);
        check("rd20_after_wr", r, 8'h5A);

        cs_low();
        spi_byte(8'h0A, 8, r);
        spi_byte(8'h1F, 8, r);
        spi_byte(8'h52, 8, r);
        #HALF;
        check("softkey_strobe", strobe_cnt, 2);
        check("softkey_addr",   last_addr,  8'h1F);
        check("softkey_data",   last_data,  8'h52);
        check("soft_before_cs", soft_cnt,   0);
        cs_high();
        check("soft_pulse_once", soft_cnt, 1);
        do_read(8'h20, r);
        check("rd20_after_soft", r, 8'h00);
        do_read(8'h0B, r);
        check("rd_status_reset", r, 8'h41);

        tx_buf[0] = 8'h0B; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
        spi_txn(4, 8);
        check("burst_b0", rx_buf[2], 8'hAD);
        check("burst_b1", rx_buf[3], AUTOINC ? 8'h1D : 8'h00);

        tx_buf[0] = 8'h0B; tx_buf[1] = 8'h01; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
        spi_txn(4, 8);
        check("burst_from01_b1", rx_buf[3], AUTOINC ? 8'hF2 : 8'h00);

        do_read(8'h01, r);
        check("rd_devid_mst", r, 8'h1D);
        do_read(8'h02, r);
        check("rd_partid", r, 8'hF2);
        do_read(8'h03, r);
        check("rd_revid", r, 8'h01);

        tx_buf[0] = 8'h0C; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        spi_txn(3, 8);
        check("badcmd_miso",   rx_buf[2],  8'h00);
        check("badcmd_err",    cmd_err,    1);
        check("badcmd_strobe", strobe_cnt, 2);
        cs_low();
        check("cmd_err_clear", cmd_err, 0);
        cs_high();

        do_write(8'h20, 8'h77);
        check("wr20_77_count", strobe_cnt, 3);
        tx_buf[0] = 8'h0A; tx_buf[1] = 8'h20; tx_buf[2] = 8'hFF;
        spi_txn(3, 4);
        check("partial_no_strobe", strobe_cnt, 3);
        do_read(8'h20, r);
        check("partial_reg_kept", r, 8'h77);

        do_write(8'h00, 8'h55);
        check("ro_no_strobe", strobe_cnt, 3);
        do_read(8'h00, r);
        check("ro_unchanged", r, 8'hAD);
        do_write(8'h0E, 8'h66);
        check("ro_last_no_strobe", strobe_cnt, 3);
        do_write(8'h0F, 8'h66);
        check("rw_first_strobe", strobe_cnt, 4);
        check("rw_first_addr",   last_addr,  8'h0F);

        do_write(8'h40, 8'h11);
        check("oor_no_strobe", strobe_cnt, 4);
        do_read(8'h40, r);
        check("oor_read_zero", r, 8'h00);

        tx_buf[0] = 8'h0B; tx_buf[1] = 8'hFF; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
        spi_txn(4, 8);
        check("wrap_b0", rx_buf[2], 8'h00);
        check("wrap_b1", rx_buf[3], AUTOINC ? 8'hAD : 8'h00);

        tx_buf[0] = 8'h0A; tx_buf[1] = 8'h30; tx_buf[2] = 8'h11; tx_buf[3] = 8'h22;
        spi_txn(4, 8);
        check("bwr_count", strobe_cnt, AUTOINC ? 6 : 5);
        check("bwr_addr",  last_addr,  AUTOINC ? 8'h31 : 8'h30);
        check("bwr_data",  last_data,  AUTOINC ? 8'h22 : 8'h11);
        do_read(8'h31, r);
        check("bwr_rd31", r, AUTOINC ? 8'h22 : 8'h00);

        spi_bus.SPI_CS = 1'b0;
        #(2*HALF);
        spi_byte(8'h0B, 8, r);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #(2*HALF);
        spi_byte(8'h00, 8, r);
        spi_byte(8'h00, 8, r);
        check("midrst_miso",    r,       8'h00);
        check("midrst_cmd_err", cmd_err, 0);
        check("midrst_busy",    busy,    1);
        cs_high();
        do_read(8'h00, r);
        check("midrst_then_read", r, 8'hAD);
        check("idle_miso", spi_bus.SPI_MISO, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
